// File: rtl/ps2_edge_detector_multi_pkg.sv
// Shared defaults, legal ranges and width helpers for the PS/2 clock-line edge detector.
package ps2_edge_detector_multi_pkg;

  localparam int DEF_SAMPLING_BIT_SIZE = 5;
  localparam int DEF_SYNC_STAGES       = 2;
  localparam int DEF_FILTER_LEN        = 3;
  localparam int DEF_IDLE_TICKS        = 64;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int FILTER_LEN_MIN  = 1;
  localparam int FILTER_LEN_MAX  = 15;

  // Filter counter only ever holds 0..FILTER_LEN-1, so 4 bits covers the legal range.
  localparam int FCNT_W = 4;

  function automatic int idle_cnt_w(input int ticks);
    return (ticks < 1) ? 1 : $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/ps2_edge_filter_ch.sv
// One PS/2 clock line: synchroniser, consecutive-sample glitch filter, edge pulses.
// With PS2_EDGE_IDLE_DETECT_EN defined, also tracks stable-high idle time.
module ps2_edge_filter_ch
  import ps2_edge_detector_multi_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILTER_LEN  = DEF_FILTER_LEN
`ifdef PS2_EDGE_IDLE_DETECT_EN
  , parameter int IDLE_TICKS = DEF_IDLE_TICKS
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic ps2_clk,
  output logic fall,
  output logic rise,
  output logic level
`ifdef PS2_EDGE_IDLE_DETECT_EN
  , output logic idle
`endif
);

  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FCNT_W-1:0]      fcnt;
  logic                   synced;
  logic                   accept;

  assign synced = sync_q[SYNC_STAGES-1];
  assign accept = tick && (synced != level) && (fcnt == FCNT_LAST);

  // Idle-high open-collector line, so the chain resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], ps2_clk};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt  <= '0;
      level <= 1'b1;
      fall  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      fall <= 1'b0;
      rise <= 1'b0;
      if (tick) begin
        if (synced == level) begin
          fcnt <= '0;
        end else if (fcnt < FCNT_LAST) begin
          fcnt <= fcnt + 1'b1;
        end else begin
          level <= synced;
          fcnt  <= '0;
          fall  <= ~synced;
          rise  <= synced;
        end
      end
    end
  end

`ifdef PS2_EDGE_IDLE_DETECT_EN
  localparam int              IW       = idle_cnt_w(IDLE_TICKS);
  localparam logic [IW-1:0]   IDLE_MAX = IW'(IDLE_TICKS);

  logic [IW-1:0] icnt;

  // Counter starts saturated so idle is consistent with its reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt <= IDLE_MAX;
      idle <= 1'b1;
    end else if (tick) begin
      if (!synced || !level) begin
        icnt <= '0;
      end else if (icnt < IDLE_MAX) begin
        icnt <= icnt + 1'b1;
        if (icnt == IDLE_MAX - 1'b1) idle <= 1'b1;
      end
      if (accept && !synced) idle <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/ps2_edge_detector_multi.sv
// Multi-channel PS/2 clock-line edge detector; owns the shared sample strobe.
// Define PS2_EDGE_IDLE_DETECT_EN to add the per-channel o_idle output.
module ps2_edge_detector_multi
  import ps2_edge_detector_multi_pkg::*;
#(
  parameter int CHANNELS          = 2,
  parameter int SAMPLING_BIT_SIZE = DEF_SAMPLING_BIT_SIZE,
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int FILTER_LEN        = DEF_FILTER_LEN
`ifdef PS2_EDGE_IDLE_DETECT_EN
  , parameter int IDLE_TICKS      = DEF_IDLE_TICKS
`endif
) (
  input  logic                clk,
  input  logic                i_sclr,
  input  logic                i_en,
  input  logic [CHANNELS-1:0] i_ps2_clk,
  output logic [CHANNELS-1:0] o_fall,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_level,
  output logic                o_tick
`ifdef PS2_EDGE_IDLE_DETECT_EN
  , output logic [CHANNELS-1:0] o_idle
`endif
);

  logic [SAMPLING_BIT_SIZE-1:0] strobe_cnt;
  logic                         tick;

  assign tick = i_en && (strobe_cnt == '1);

  always_ff @(posedge clk or posedge i_sclr) begin
    if (i_sclr) begin
      strobe_cnt <= '0;
      o_tick     <= 1'b0;
    end else begin
      o_tick <= tick;
      if (i_en) strobe_cnt <= strobe_cnt + 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    ps2_edge_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
`ifdef PS2_EDGE_IDLE_DETECT_EN
      , .IDLE_TICKS(IDLE_TICKS)
`endif
    ) u_ch (
      .clk     (clk),
      .rst     (i_sclr),
      .tick    (tick),
      .ps2_clk (i_ps2_clk[c]),
      .fall    (o_fall[c]),
      .rise    (o_rise[c]),
      .level   (o_level[c])
`ifdef PS2_EDGE_IDLE_DETECT_EN
      , .idle  (o_idle[c])
`endif
    );
  end

endmodule
